// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC and a sync-read instruction memory, accepts a sequential
// program load, and presents fetched words to decode through a valid/ready output.
module inst_fetch_unit #(
    parameter int                   PC_WIDTH   = 16,
    parameter int                   ISA_WIDTH  = 16,
    parameter int                   ADDR_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
    parameter logic [ISA_WIDTH-1:0] HALT_INST  = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 load_valid,
    input  logic [ISA_WIDTH-1:0] load_data,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic                 load_err,
    input  logic                 run_start,
    input  logic                 redirect_valid,
    input  logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ISA_WIDTH-1:0] out_inst,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic [1:0]           state
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    // Handshake: a word moves to decode on any rising edge where out_valid and out_ready are both
    // high; out_inst/out_pc stay stable while out_valid is high and out_ready is low.

    state_t                state_q;
    logic [ISA_WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH:0]   load_addr;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   fetch_addr;
    logic                  load_room;
    logic                  load_write;
    logic                  halt_xfer;
    logic                  advance;

    // The extra top bit of load_addr marks "memory full"; the address then holds there.
    assign load_room  = !load_addr[ADDR_WIDTH];
    assign load_write = (state_q == S_LOAD) && load_valid && load_room;
    assign fetch_addr = redirect_valid ? redirect_pc : pc;
    assign halt_xfer  = (state_q == S_RUN) && out_valid && out_ready && (out_inst == HALT_INST);
    assign advance    = (state_q == S_RUN) &&
                        (!out_valid || (out_ready && (out_inst != HALT_INST)));

    assign state      = state_q;
    assign load_ready = (state_q == S_LOAD);

    always_ff @(posedge clk) begin
        if (load_write) begin
            mem[load_addr[ADDR_WIDTH-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc        <= RESET_PC;
            load_addr <= '0;
            load_err  <= 1'b0;
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_pc    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_start) begin
                        state_q   <= S_LOAD;
                        load_addr <= '0;
                        load_err  <= 1'b0;
                    end else if (run_start) begin
                        state_q   <= S_RUN;
                        pc        <= RESET_PC;
                        out_valid <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (load_valid) begin
                        if (load_room) begin
                            load_addr <= load_addr + (ADDR_WIDTH + 1)'(1);
                        end else begin
                            load_err <= 1'b1;
                        end
                        // A dropped final word still closes the load.
                        if (load_last) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_RUN: begin
                    if (halt_xfer) begin
                        state_q   <= S_HALT;
                        out_valid <= 1'b0;
                    end else if (advance) begin
                        out_inst  <= mem[fetch_addr[ADDR_WIDTH-1:0]];
                        out_pc    <= fetch_addr;
                        out_valid <= 1'b1;
                        pc        <= fetch_addr + PC_WIDTH'(1);
                    end else if (redirect_valid) begin
                        // Stalled word is on the wrong path: drop it and fetch the target next.
                        pc        <= redirect_pc;
                        out_valid <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (run_start) begin
                        state_q   <= S_RUN;
                        pc        <= RESET_PC;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
